fb_multibuf: RTL and testbench
==============================

# fb_multibuf

Parametrised N-buffer framebuffer for the LED panel pipeline, generalising the fixed two-bank swap buffer to 2-4 banks with explicit frame commit and newest-complete-frame selection (triple buffering when NUM_BUFS ≥ 3). Sits between the upstream frame receiver, already synchronised into sys_clk, and the panel scan engine. Banks are written and read in one clock domain. Buffer ownership is tracked per bank by a small state machine, so writer and scanner never touch the same bank.

## Interface
- DATA_WIDTH, 20, pixel word width
- ADDR_WIDTH, 14, address width per bank (depth 2^ADDR_WIDTH)
- NUM_BUFS, 3, bank count, legal 2..4; other values are a compile-time error
- BUF_W, derived, clog2(NUM_BUFS), not overridable
- sys_clk  in  1  single clock, rising edge
- sys_rst_n  in  1  asynchronous active-low reset
- wdata  in  DATA_WIDTH  write pixel
- waddr  in  ADDR_WIDTH  write address within current write bank
- we  in  1  write strobe
- commit  in  1  one-cycle pulse: current write bank holds a complete frame
- wr_ready  out  1  a write bank is allocated; we/commit honoured only when high
- wr_buf  out  BUF_W  index of current write bank
- raddr  in  ADDR_WIDTH  read address within display bank
- re  in  1  read strobe
- rdata  out  DATA_WIDTH  read data, 1-cycle latency
- frame_start  in  1  scanner frame boundary pulse
- swapped  out  1  one-cycle pulse: display bank changed
- rd_buf  out  BUF_W  index of display bank

## Operation
- Storage: one inferred array of NUM_BUFS·2^ADDR_WIDTH words, addressed {bank, addr}. One write port and one read port. No init file; contents are undefined after power-up.
- Per-bank state: FREE, WRITING, READY, DISPLAY. At most one bank is WRITING, one READY, and exactly one DISPLAY.
- Reset: bank 0 = DISPLAY, bank 1 = WRITING, others FREE.
- Write: a we with wr_ready=1 writes wdata to {wr_buf, waddr}. A we with wr_ready=0 is dropped.
- Commit (wr_ready=1): WRITING→READY. If a READY bank already exists, it becomes FREE (newest frame wins) and the drop is counted (see Configuration).
- Allocation: after commit, the lowest-index FREE bank becomes WRITING. If there is none (always the case for NUM_BUFS=2 until a swap), wr_ready drops to 0. A commit with wr_ready=0 is ignored.
- frame_start with a READY bank present: DISPLAY→FREE, READY→DISPLAY, swapped pulses.
- frame_start with no READY bank: no change and no pulse.
- Same-cycle commit and frame_start: commit is evaluated first. The just-committed bank goes straight to DISPLAY, and the freed display bank is available for allocation on that same edge.
- Read: a re samples {rd_buf, raddr} at issue. A read issued in the frame_start cycle still uses the old bank. rdata holds its last value when re=0.

## Timing
- Reset values: rdata=0, swapped=0, wr_ready=1, wr_buf=1, rd_buf=0, stats counters 0.
- Write-to-read visibility: a word written at cycle t is readable from t+1, once its bank is DISPLAY.
- Commit at t: wr_buf and wr_ready reflect the new allocation at t+1.
- frame_start at t: rd_buf and swapped update at t+1. swapped is high for exactly one cycle.
- Read latency: exactly 1 cycle, fully pipelined, one read per cycle.
- Reset asserted mid-frame: bank states return to reset values immediately. Bank contents are not cleared.

## Configuration
- FB_MULTIBUF_STATS_EN defined: adds outputs frames_shown (16 bit, +1 per swapped) and frames_dropped (16 bit, +1 per READY bank discarded on commit). Both saturate at 0xFFFF and are cleared by reset.
- Not defined: these ports and counters are absent; functional behaviour is otherwise identical.

## Test plan
- Reset, NUM_BUFS=3 → wr_buf=1, rd_buf=0, wr_ready=1, swapped=0.
- Write 0xABCDE at addr 5, commit, frame_start → swapped pulse, rd_buf=1; read addr 5 returns 0xABCDE one cycle after re; wr_buf=2.
- NUM_BUFS=3: commit twice without frame_start → first READY bank freed, frames_dropped=1; frame_start displays the second committed bank.
- NUM_BUFS=2: commit → wr_ready=0; we at addr 0 with 0x12345 ignored (old value unchanged); frame_start → wr_ready=1, wr_buf=0.
- commit and frame_start in the same cycle → committed bank displayed at t+1 with swapped=1; wr_buf = previously displayed bank.
- frame_start with nothing READY → rd_buf unchanged, no swapped pulse.

Source files
------------

// File: rtl/fb_multibuf_if.sv
`default_nettype none
// ============================================================================
// Module   : fb_multibuf_if
// Brief    : Writer / scanner bus of the N-bank framebuffer.
// Revision : 1.0 - initial release
// ============================================================================
interface fb_multibuf_if #(
    parameter int DATA_WIDTH = 20,
    parameter int ADDR_WIDTH = 14,
    parameter int NUM_BUFS   = 3
);
    localparam int BUF_W = $clog2(NUM_BUFS);

    logic [DATA_WIDTH-1:0] wdata;
    logic [ADDR_WIDTH-1:0] waddr;
    logic                  we;
    logic                  commit;
    logic                  wr_ready;
    logic [BUF_W-1:0]      wr_buf;
    logic [ADDR_WIDTH-1:0] raddr;
    logic                  re;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  frame_start;
    logic                  swapped;
    logic [BUF_W-1:0]      rd_buf;

    modport master (
        output wdata, waddr, we, commit, raddr, re, frame_start,
        input  wr_ready, wr_buf, rdata, swapped, rd_buf
    );

    modport slave (
        input  wdata, waddr, we, commit, raddr, re, frame_start,
        output wr_ready, wr_buf, rdata, swapped, rd_buf
    );
endinterface
`default_nettype wire

// File: rtl/fb_multibuf.sv
`default_nettype none
// ============================================================================
// Module   : fb_multibuf
// Brief    : 2..4 bank framebuffer with commit and newest-frame display.
//            Optional stats counters enabled by FB_MULTIBUF_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module fb_multibuf #(
    parameter int DATA_WIDTH = 20,
    parameter int ADDR_WIDTH = 14,
    parameter int NUM_BUFS   = 3
) (
    input  logic          sys_clk,
    input  logic          sys_rst_n,
    fb_multibuf_if.slave  bus
`ifdef FB_MULTIBUF_STATS_EN
    ,
    output logic [15:0]   frames_shown,
    output logic [15:0]   frames_dropped
`endif
);
    localparam int BUF_W = $clog2(NUM_BUFS);
    localparam int DEPTH = NUM_BUFS * (2 ** ADDR_WIDTH);

    generate
        if (NUM_BUFS < 2 || NUM_BUFS > 4) begin : g_bad_num_bufs
            $error("fb_multibuf: NUM_BUFS must be in 2..4");
        end
    endgenerate

    typedef enum logic [1:0] {
        FREE    = 2'd0,
        WRITING = 2'd1,
        READY   = 2'd2,
        DISPLAY = 2'd3
    } bank_state_t;

    bank_state_t           r_state    [NUM_BUFS];
    bank_state_t           w_state_nx [NUM_BUFS];
    logic [BUF_W-1:0]      r_wr_buf, w_wr_buf_nx;
    logic [BUF_W-1:0]      r_rd_buf, w_rd_buf_nx;
    logic                  r_wr_ready, w_wr_ready_nx;
    logic                  r_swapped;
    logic                  w_commit, w_swap, w_drop, w_alloc_found;
    logic [BUF_W-1:0]      w_alloc_idx;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Commit resolves first so a same-cycle frame_start sees the new READY bank
    // and the bank it frees is eligible for allocation on the same edge.
    always_comb begin
        w_state_nx    = r_state;
        w_wr_buf_nx   = r_wr_buf;
        w_rd_buf_nx   = r_rd_buf;
        w_wr_ready_nx = r_wr_ready;
        w_commit      = bus.commit && r_wr_ready;
        w_swap        = 1'b0;
        w_drop        = 1'b0;
        w_alloc_found = 1'b0;
        w_alloc_idx   = '0;
        if (w_commit) begin
            for (int i = 0; i < NUM_BUFS; i++) begin
                if (w_state_nx[i] == READY) begin
                    w_state_nx[i] = FREE;
                    w_drop        = 1'b1;
                end
            end
            w_state_nx[r_wr_buf] = READY;
            w_wr_ready_nx        = 1'b0;
        end
        if (bus.frame_start) begin
            for (int i = 0; i < NUM_BUFS; i++) begin
                if (w_state_nx[i] == READY) begin
                    w_swap      = 1'b1;
                    w_rd_buf_nx = BUF_W'(i);
                end
            end
            if (w_swap) begin
                w_state_nx[r_rd_buf]    = FREE;
                w_state_nx[w_rd_buf_nx] = DISPLAY;
            end
        end
        if (!w_wr_ready_nx) begin
            for (int i = NUM_BUFS - 1; i >= 0; i--) begin
                if (w_state_nx[i] == FREE) begin
                    w_alloc_found = 1'b1;
                    w_alloc_idx   = BUF_W'(i);
                end
            end
            if (w_alloc_found) begin
                w_state_nx[w_alloc_idx] = WRITING;
                w_wr_buf_nx             = w_alloc_idx;
                w_wr_ready_nx           = 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int i = 0; i < NUM_BUFS; i++) begin
                if (i == 0)      r_state[i] <= DISPLAY;
                else if (i == 1) r_state[i] <= WRITING;
                else             r_state[i] <= FREE;
            end
            r_wr_buf   <= BUF_W'(1);
            r_rd_buf   <= '0;
            r_wr_ready <= 1'b1;
            r_swapped  <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_wr_buf   <= w_wr_buf_nx;
            r_rd_buf   <= w_rd_buf_nx;
            r_wr_ready <= w_wr_ready_nx;
            r_swapped  <= w_swap;
        end
    end

    // Storage is never reset; only the output register is.
    always_ff @(posedge sys_clk) begin
        if (bus.we && r_wr_ready) begin
            mem[{r_wr_buf, bus.waddr}] <= bus.wdata;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_rdata <= '0;
        end else if (bus.re) begin
            r_rdata <= mem[{r_rd_buf, bus.raddr}];
        end
    end

    assign bus.wr_ready = r_wr_ready;
    assign bus.wr_buf   = r_wr_buf;
    assign bus.rd_buf   = r_rd_buf;
    assign bus.swapped  = r_swapped;
    assign bus.rdata    = r_rdata;

`ifdef FB_MULTIBUF_STATS_EN
    logic [15:0] r_frames_shown;
    logic [15:0] r_frames_dropped;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_frames_shown   <= '0;
            r_frames_dropped <= '0;
        end else begin
            if (w_swap && r_frames_shown != 16'hFFFF) begin
                r_frames_shown <= r_frames_shown + 16'd1;
            end
            if (w_drop && r_frames_dropped != 16'hFFFF) begin
                r_frames_dropped <= r_frames_dropped + 16'd1;
            end
        end
    end

    assign frames_shown   = r_frames_shown;
    assign frames_dropped = r_frames_dropped;
`endif
endmodule
`default_nettype wire

// File: tb/tb_fb_multibuf.sv
`default_nettype none
// ============================================================================
// Module   : tb_fb_multibuf
// Brief    : Self-checking bench for fb_multibuf (3-bank and 2-bank instances).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fb_multibuf;
    localparam int DW = 20;
    localparam int AW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fb_multibuf_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_BUFS(3)) if3 ();
    fb_multibuf_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_BUFS(2)) if2 ();

`ifdef FB_MULTIBUF_STATS_EN
    logic [15:0] shown3, dropped3, shown2, dropped2;
`endif

    fb_multibuf #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_BUFS(3)) u3 (
        .sys_clk(clk), .sys_rst_n(rst_n), .bus(if3)
`ifdef FB_MULTIBUF_STATS_EN
        , .frames_shown(shown3), .frames_dropped(dropped3)
`endif
    );

    fb_multibuf #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_BUFS(2)) u2 (
        .sys_clk(clk), .sys_rst_n(rst_n), .bus(if2)
`ifdef FB_MULTIBUF_STATS_EN
        , .frames_shown(shown2), .frames_dropped(dropped2)
`endif
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: bank roles as indices (-1 = none), memory as a sparse map.
    int          m_nb   [2];
    int          m_disp [2];
    int          m_wr   [2];
    int          m_rdy  [2];
    int          m_shown[2];
    int          m_drop [2];
    bit          m_swp  [2];
    logic [DW-1:0] m_rd [2];
    bit          m_rd_known [2];
    logic [DW-1:0] m_mem [int];

    function automatic int key(input int k, input int bank, input int addr);
        return ((k * 4 + bank) * 16) + addr;
    endfunction

    task automatic m_reset(input int k);
        m_disp[k] = 0; m_wr[k] = 1; m_rdy[k] = -1;
        m_shown[k] = 0; m_drop[k] = 0; m_swp[k] = 0;
        m_rd[k] = '0; m_rd_known[k] = 1;
    endtask

    task automatic m_step(input int k, input bit we, input int waddr, input logic [DW-1:0] wdata,
                          input bit commit, input bit fs, input bit re, input int raddr);
        if (re) begin
            if (m_mem.exists(key(k, m_disp[k], raddr))) begin
                m_rd[k] = m_mem[key(k, m_disp[k], raddr)];
                m_rd_known[k] = 1;
            end else begin
                m_rd_known[k] = 0;
            end
        end
        if (we && m_wr[k] >= 0) m_mem[key(k, m_wr[k], waddr)] = wdata;
        m_swp[k] = 0;
        if (commit && m_wr[k] >= 0) begin
            if (m_rdy[k] >= 0 && m_drop[k] < 65535) m_drop[k]++;
            m_rdy[k] = m_wr[k];
            m_wr[k] = -1;
        end
        if (fs && m_rdy[k] >= 0) begin
            m_disp[k] = m_rdy[k];
            m_rdy[k] = -1;
            m_swp[k] = 1;
            if (m_shown[k] < 65535) m_shown[k]++;
        end
        if (m_wr[k] < 0) begin
            for (int b = 0; b < m_nb[k]; b++) begin
                if (m_wr[k] < 0 && b != m_disp[k] && b != m_rdy[k]) m_wr[k] = b;
            end
        end
    endtask

    task automatic set_idle();
        if3.we = 0; if3.waddr = '0; if3.wdata = '0; if3.commit = 0;
        if3.frame_start = 0; if3.re = 0; if3.raddr = '0;
        if2.we = 0; if2.waddr = '0; if2.wdata = '0; if2.commit = 0;
        if2.frame_start = 0; if2.re = 0; if2.raddr = '0;
    endtask

    // One clock edge; the model consumes the inputs that were present at the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        m_step(0, if3.we, int'(if3.waddr), if3.wdata, if3.commit, if3.frame_start, if3.re, int'(if3.raddr));
        m_step(1, if2.we, int'(if2.waddr), if2.wdata, if2.commit, if2.frame_start, if2.re, int'(if2.raddr));
    endtask

    task automatic check_model(input int k);
        logic rdy, sw;
        logic [1:0] wb, rb;
        logic [DW-1:0] rd;
        string p;
        p = $sformatf("u%0d_", m_nb[k]);
        if (k == 0) begin
            rdy = if3.wr_ready; wb = if3.wr_buf; rb = if3.rd_buf; sw = if3.swapped; rd = if3.rdata;
        end else begin
            rdy = if2.wr_ready; wb = 2'(if2.wr_buf); rb = 2'(if2.rd_buf); sw = if2.swapped; rd = if2.rdata;
        end
        chk({p, "wr_ready"}, 32'(rdy), 32'(m_wr[k] >= 0));
        if (m_wr[k] >= 0) chk({p, "wr_buf"}, 32'(wb), 32'(m_wr[k]));
        chk({p, "rd_buf"}, 32'(rb), 32'(m_disp[k]));
        chk({p, "swapped"}, 32'(sw), 32'(m_swp[k]));
        if (m_rd_known[k]) chk({p, "rdata"}, 32'(rd), 32'(m_rd[k]));
`ifdef FB_MULTIBUF_STATS_EN
        if (k == 0) begin
            chk({p, "frames_shown"}, 32'(shown3), 32'(m_shown[k]));
            chk({p, "frames_dropped"}, 32'(dropped3), 32'(m_drop[k]));
        end else begin
            chk({p, "frames_shown"}, 32'(shown2), 32'(m_shown[k]));
            chk({p, "frames_dropped"}, 32'(dropped2), 32'(m_drop[k]));
        end
`endif
    endtask

    typedef struct {
        bit            we;
        logic [AW-1:0] waddr;
        logic [DW-1:0] wdata;
        bit            commit;
        bit            fs;
        bit            re;
        logic [AW-1:0] raddr;
        bit            x_wr_ready;
        logic [1:0]    x_wr_buf;
        logic [1:0]    x_rd_buf;
        bit            x_swapped;
        bit            chk_rdata;
        logic [DW-1:0] x_rdata;
    } vec_t;

    vec_t vecs [10];

    initial begin
        //           we wa  wdata     cm fs re ra  rdy wb rb sw cr  rdata
        vecs[0] = '{1, 5, 20'hABCDE, 0, 0, 0, 0,  1, 1, 0, 0, 0, 20'h0};
        vecs[1] = '{0, 0, 20'h0,     1, 0, 0, 0,  1, 2, 0, 0, 0, 20'h0};
        vecs[2] = '{0, 0, 20'h0,     0, 1, 0, 0,  1, 2, 1, 1, 0, 20'h0};
        vecs[3] = '{0, 0, 20'h0,     0, 0, 1, 5,  1, 2, 1, 0, 1, 20'hABCDE};
        vecs[4] = '{0, 0, 20'h0,     0, 0, 0, 0,  1, 2, 1, 0, 1, 20'hABCDE};
        vecs[5] = '{0, 0, 20'h0,     0, 1, 0, 0,  1, 2, 1, 0, 0, 20'h0};
        vecs[6] = '{1, 3, 20'h11111, 1, 0, 0, 0,  1, 0, 1, 0, 0, 20'h0};
        vecs[7] = '{0, 0, 20'h0,     1, 0, 0, 0,  1, 2, 1, 0, 0, 20'h0};
        vecs[8] = '{0, 0, 20'h0,     0, 1, 0, 0,  1, 2, 0, 1, 0, 20'h0};
        vecs[9] = '{0, 0, 20'h0,     1, 1, 0, 0,  1, 0, 2, 1, 0, 20'h0};

        m_nb[0] = 3; m_nb[1] = 2;
        m_reset(0); m_reset(1);
        set_idle();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        chk("rst_wr_buf", 32'(if3.wr_buf), 32'd1);
        chk("rst_rd_buf", 32'(if3.rd_buf), 32'd0);
        chk("rst_wr_ready", 32'(if3.wr_ready), 32'd1);
        chk("rst_swapped", 32'(if3.swapped), 32'd0);
        chk("rst_rdata", 32'(if3.rdata), 32'd0);

        for (int i = 0; i < 10; i++) begin
            if3.we = vecs[i].we; if3.waddr = vecs[i].waddr; if3.wdata = vecs[i].wdata;
            if3.commit = vecs[i].commit; if3.frame_start = vecs[i].fs;
            if3.re = vecs[i].re; if3.raddr = vecs[i].raddr;
            tick();
            chk($sformatf("vec%0d_wr_ready", i), 32'(if3.wr_ready), 32'(vecs[i].x_wr_ready));
            chk($sformatf("vec%0d_wr_buf", i), 32'(if3.wr_buf), 32'(vecs[i].x_wr_buf));
            chk($sformatf("vec%0d_rd_buf", i), 32'(if3.rd_buf), 32'(vecs[i].x_rd_buf));
            chk($sformatf("vec%0d_swapped", i), 32'(if3.swapped), 32'(vecs[i].x_swapped));
            if (vecs[i].chk_rdata) chk($sformatf("vec%0d_rdata", i), 32'(if3.rdata), 32'(vecs[i].x_rdata));
        end
        set_idle();
`ifdef FB_MULTIBUF_STATS_EN
        chk("tbl_frames_shown", 32'(shown3), 32'd3);
        chk("tbl_frames_dropped", 32'(dropped3), 32'd1);
`endif

        // Two-bank instance: no free bank after commit until the next swap.
        if2.we = 1; if2.waddr = 0; if2.wdata = 20'h0AAAA;
        tick();
        if2.we = 0; if2.commit = 1;
        tick();
        chk("nb2_commit_wr_ready", 32'(if2.wr_ready), 32'd0);
        if2.commit = 0; if2.we = 1; if2.wdata = 20'h12345;
        tick();
        chk("nb2_blocked_wr_ready", 32'(if2.wr_ready), 32'd0);
        if2.we = 0; if2.frame_start = 1;
        tick();
        chk("nb2_fs_swapped", 32'(if2.swapped), 32'd1);
        chk("nb2_fs_rd_buf", 32'(if2.rd_buf), 32'd1);
        chk("nb2_fs_wr_ready", 32'(if2.wr_ready), 32'd1);
        chk("nb2_fs_wr_buf", 32'(if2.wr_buf), 32'd0);
        if2.frame_start = 0; if2.re = 1; if2.raddr = 0;
        tick();
        chk("nb2_dropped_write_rdata", 32'(if2.rdata), 32'h0AAAA);
        chk("nb2_swapped_one_cycle", 32'(if2.swapped), 32'd0);
        set_idle();
        tick();
        check_model(0); check_model(1);

        for (int c = 0; c < 600; c++) begin
            if (c == 300) begin
                // Asynchronous reset mid-frame: roles reset at once, contents persist.
                set_idle();
                rst_n = 1'b0;
                #2;
                chk("midrst_wr_buf", 32'(if3.wr_buf), 32'd1);
                chk("midrst_rd_buf", 32'(if3.rd_buf), 32'd0);
                chk("midrst_wr_ready", 32'(if3.wr_ready), 32'd1);
                chk("midrst_rdata", 32'(if3.rdata), 32'd0);
                chk("midrst_nb2_wr_ready", 32'(if2.wr_ready), 32'd1);
                m_reset(0); m_reset(1);
                @(posedge clk);
                #1 rst_n = 1'b1;
            end
            if3.we = 1'($urandom_range(0, 1)); if3.waddr = AW'($urandom_range(0, 15));
            if3.wdata = DW'($urandom); if3.commit = ($urandom_range(0, 5) == 0);
            if3.frame_start = ($urandom_range(0, 5) == 0); if3.re = 1'($urandom_range(0, 1));
            if3.raddr = AW'($urandom_range(0, 15));
            if2.we = 1'($urandom_range(0, 1)); if2.waddr = AW'($urandom_range(0, 15));
            if2.wdata = DW'($urandom); if2.commit = ($urandom_range(0, 4) == 0);
            if2.frame_start = ($urandom_range(0, 4) == 0); if2.re = 1'($urandom_range(0, 1));
            if2.raddr = AW'($urandom_range(0, 15));
            tick();
            check_model(0);
            check_model(1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
